serial_frame_rx: RTL and testbench

- Framed serial-to-parallel receiver (deserializer). It is the capture end of a one-bit-per-clock serial link whose transmit side is a clocked shift/flop chain.
- Samples a synchronous serial line and detects a start bit. It then shifts in WIDTH data bits, LSB first, and checks the stop bit.
- Presents the assembled word with a one-cycle valid strobe, or flags a framing error.
- Sits between a serial source in the same clock domain and a parallel consumer.

---
 rtl/serial_frame_rx.sv | 98 +++++++++
 tb/tb_serial_frame_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial-to-parallel receiver: start bit 0, WIDTH data bits LSB first, stop bit 1.
// Emits a one-cycle data_valid on a good stop bit or frame_err on a bad one.
module serial_frame_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;

  logic cnt_clr_c;
  logic shift_en_c;
  logic load_c;
  logic err_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!rx_in) state_nxt = DATA;
      DATA: if (bit_cnt == LAST_BIT) state_nxt = STOP;
      STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    cnt_clr_c  = 1'b0;
    shift_en_c = 1'b0;
    load_c     = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: cnt_clr_c = !rx_in;
      DATA: shift_en_c = 1'b1;
      STOP: begin
        load_c = rx_in;
        err_c  = !rx_in;
      end
      default: ;
    endcase
  end

  // Shift register, bit counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= load_c;
      frame_err  <= err_c;
      busy       <= (state_nxt != IDLE);
      if (cnt_clr_c) begin
        bit_cnt <= '0;
      end
      if (shift_en_c) begin
        // LSB-first line: each new bit enters at the MSB and walks down
        shift_reg <= (shift_reg >> 1) | (WIDTH'(rx_in) << (WIDTH - 1));
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
      if (load_c) begin
        data_out <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: WIDTH=8 and WIDTH=1 instances checked cycle by cycle
// against a frame-level model that scans the driven bit stream.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       rx8;
  logic       rx1;
  logic [7:0] d8;
  logic [0:0] d1;
  logic       v8, e8, b8;
  logic       v1, e1, b1;

  serial_frame_rx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8),
    .data_out(d8), .data_valid(v8), .frame_err(e8), .busy(b8)
  );

  serial_frame_rx #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .rx_in(rx1),
    .data_out(d1), .data_valid(v1), .frame_err(e1), .busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic        stim[$];
  logic        xv[$];
  logic        xe[$];
  logic        xb[$];
  logic [31:0] xd[$];
  logic [31:0] exp_d8;
  logic [31:0] exp_d1;

  int          obs_valid;
  int          obs_err;
  int          valid_at[$];
  logic [31:0] valid_word[$];

  task automatic add_idle(input int n);
    repeat (n) stim.push_back(1'b1);
  endtask

  task automatic add_frame(input int w, input logic [31:0] word, input logic stop);
    stim.push_back(1'b0);
    for (int b = 0; b < w; b++) stim.push_back(word[b]);
    stim.push_back(stop);
  endtask

  // Frame-level expectation: every 0 seen while idle opens a frame of w+2 bits
  task automatic model(input int w, input logic [31:0] d0);
    int          n;
    int          pos;
    logic [31:0] word;
    logic [31:0] cur;
    logic        upd[$];
    logic [31:0] upd_w[$];
    n = stim.size();
    xv.delete(); xe.delete(); xb.delete(); xd.delete();
    for (int i = 0; i < n; i++) begin
      xv.push_back(1'b0); xe.push_back(1'b0); xb.push_back(1'b0);
      upd.push_back(1'b0); upd_w.push_back(32'd0);
    end
    pos = 0;
    while (pos < n) begin
      if (stim[pos] == 1'b0 && pos + w + 1 < n) begin
        word = 32'd0;
        for (int b = 0; b < w; b++) word[b] = stim[pos + 1 + b];
        for (int e = pos; e <= pos + w; e++) xb[e] = 1'b1;
        if (stim[pos + w + 1]) begin
          xv[pos + w + 1]    = 1'b1;
          upd[pos + w + 1]   = 1'b1;
          upd_w[pos + w + 1] = word;
        end else begin
          xe[pos + w + 1] = 1'b1;
        end
        pos += w + 2;
      end else begin
        pos++;
      end
    end
    cur = d0;
    for (int i = 0; i < n; i++) begin
      if (upd[i]) cur = upd_w[i];
      xd.push_back(cur);
    end
  endtask

  task automatic run_stream(input int w, input string tag);
    logic        ov, oe, ob;
    logic [31:0] od;
    int          n;
    model(w, (w == 8) ? exp_d8 : exp_d1);
    n = stim.size();
    obs_valid = 0;
    obs_err   = 0;
    valid_at.delete();
    valid_word.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (w == 8) begin
        rx8 = stim[i]; rx1 = 1'b1;
      end else begin
        rx1 = stim[i]; rx8 = 1'b1;
      end
      @(posedge clk);
      #1;
      ov = (w == 8) ? v8 : v1;
      oe = (w == 8) ? e8 : e1;
      ob = (w == 8) ? b8 : b1;
      od = (w == 8) ? 32'(d8) : 32'(d1);
      n_total++;
      if (ov !== xv[i]) $display("FAIL %s data_valid edge %0d: got %b want %b", tag, i, ov, xv[i]);
      else n_pass++;
      n_total++;
      if (oe !== xe[i]) $display("FAIL %s frame_err edge %0d: got %b want %b", tag, i, oe, xe[i]);
      else n_pass++;
      n_total++;
      if (ob !== xb[i]) $display("FAIL %s busy edge %0d: got %b want %b", tag, i, ob, xb[i]);
      else n_pass++;
      n_total++;
      if (od !== xd[i]) $display("FAIL %s data_out edge %0d: got %h want %h", tag, i, od, xd[i]);
      else n_pass++;
      if (ov === 1'b1) begin
        obs_valid++;
        valid_at.push_back(i);
        valid_word.push_back(od);
      end
      if (oe === 1'b1) obs_err++;
    end
    if (w == 8) exp_d8 = xd[n-1];
    else        exp_d1 = xd[n-1];
    stim.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; rx8 = 1'b1; rx1 = 1'b1;
    exp_d8 = 32'd0; exp_d1 = 32'd0;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({d8, v8, e8, b8, d1, v1, e1, b1} !== 14'd0)
      $display("FAIL reset_initial outputs: got %b want 0", {d8, v8, e8, b8, d1, v1, e1, b1});
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    add_idle(1); add_frame(8, 32'h96, 1'b1); add_idle(2);
    run_stream(8, "pre_reset8");
    add_idle(1); add_frame(1, 32'h1, 1'b1); add_idle(2);
    run_stream(1, "pre_reset1");
    // Leave both receivers mid-frame, then reset between clock edges
    @(negedge clk) begin rx8 = 1'b0; rx1 = 1'b0; end
    @(negedge clk) begin rx8 = 1'b1; rx1 = 1'b1; end
    @(posedge clk);
    #3 rst = 1'b1;
    rx8 = 1'($urandom); rx1 = 1'($urandom);
    #1;
    n_total++;
    if ({d8, v8, e8, b8, d1, v1, e1, b1} !== 14'd0)
      $display("FAIL reset_async outputs: got %b want 0", {d8, v8, e8, b8, d1, v1, e1, b1});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 rx8 = 1'($urandom); rx1 = 1'($urandom);
      n_total++;
      if ({d8, v8, e8, b8, d1, v1, e1, b1} !== 14'd0)
        $display("FAIL reset_hold outputs cycle %0d: got %b want 0", i, {d8, v8, e8, b8, d1, v1, e1, b1});
      else n_pass++;
    end
    @(negedge clk) begin rst = 1'b0; rx8 = 1'b1; rx1 = 1'b1; end
    exp_d8 = 32'd0; exp_d1 = 32'd0;
  endtask

  task automatic test_single();
    add_idle(2); add_frame(8, 32'hA5, 1'b1); add_idle(3);
    run_stream(8, "single");
    n_total++;
    if (obs_valid != 1 || valid_at[0] != 11)
      $display("FAIL single strobe: got %0d pulses first at %0d want 1 at 11", obs_valid, valid_at[0]);
    else n_pass++;
    n_total++;
    if (d8 !== 8'hA5) $display("FAIL single data_out: got %h want a5", d8);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    add_idle(2); add_frame(8, 32'h3C, 1'b1); add_frame(8, 32'hFF, 1'b1); add_idle(3);
    run_stream(8, "b2b");
    n_total++;
    if (valid_at.size() != 2 || valid_at[1] - valid_at[0] != 10)
      $display("FAIL b2b spacing: got %0d pulses gap %0d want 2 gap 10",
               valid_at.size(), valid_at[1] - valid_at[0]);
    else n_pass++;
    n_total++;
    if (valid_word[0] !== 32'h3C || valid_word[1] !== 32'hFF)
      $display("FAIL b2b words: got %h %h want 3c ff", valid_word[0], valid_word[1]);
    else n_pass++;
  endtask

  task automatic test_framing_break();
    add_idle(2); add_frame(8, 32'h5A, 1'b1); add_frame(8, 32'h81, 1'b0);
    repeat (30) stim.push_back(1'b0);
    add_idle(12);
    run_stream(8, "framing");
    n_total++;
    if (obs_err != 4 || obs_valid != 1)
      $display("FAIL framing strobes: got err %0d valid %0d want err 4 valid 1", obs_err, obs_valid);
    else n_pass++;
    n_total++;
    if (d8 !== 8'h5A) $display("FAIL framing data_out: got %h want 5a", d8);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    add_frame(8, 32'hC3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) rx8 = stim[i];
      @(posedge clk);
      #1;
      n_total++;
      if ({v8, e8, b8} !== 3'b001)
        $display("FAIL midframe partial edge %0d: got v/e/busy %b want 001", i, {v8, e8, b8});
      else n_pass++;
    end
    stim.delete();
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({d8, v8, e8, b8} !== 11'd0) $display("FAIL midframe reset: got %b want 0", {d8, v8, e8, b8});
    else n_pass++;
    @(negedge clk) begin rst = 1'b0; rx8 = 1'b1; end
    exp_d8 = 32'd0;
    add_idle(2); add_frame(8, 32'h12, 1'b1); add_idle(3);
    run_stream(8, "midframe");
    n_total++;
    if (obs_valid != 1 || obs_err != 0 || d8 !== 8'h12)
      $display("FAIL midframe resume: got valid %0d err %0d data %h want 1 0 12", obs_valid, obs_err, d8);
    else n_pass++;
  endtask

  task automatic test_idle_and_width1();
    add_idle(100);
    run_stream(8, "idle");
    n_total++;
    if (obs_valid + obs_err != 0 || b8 !== 1'b0)
      $display("FAIL idle strobes: got %0d busy %b want 0 0", obs_valid + obs_err, b8);
    else n_pass++;
    add_idle(2); add_frame(1, 32'h1, 1'b1); add_idle(3);
    run_stream(1, "width1");
    n_total++;
    if (obs_valid != 1 || valid_at[0] != 4 || d1 !== 1'b1)
      $display("FAIL width1 frame: got %0d pulses at %0d data %b want 1 at 4 data 1", obs_valid, valid_at[0], d1);
    else n_pass++;
  endtask

  task automatic test_random();
    int ws[2];
    ws[0] = 8;
    ws[1] = 1;
    for (int k = 0; k < 2; k++) begin
      add_idle(2);
      repeat (25) begin
        add_frame(ws[k], $urandom, ($urandom_range(0, 4) != 0));
        add_idle($urandom_range(0, 3));
      end
      repeat (40) stim.push_back(1'($urandom_range(0, 1)));
      add_idle(ws[k] + 2);
      run_stream(ws[k], (k == 0) ? "random8" : "random1");
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_framing_break();
    test_reset_midframe();
    test_idle_and_width1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
